// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program-counter / return-address-stack block:
// the operation encoding used by the decoder and the occupancy width helper.
package pc_stack_pkg;

    // Listed in increasing priority. The decoder enforces the priority itself.
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_INC,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_e;

    // Bits needed to count 0..entries inclusive.
    function automatic int depth_w(input int entries);
        return $clog2(entries + 1);
    endfunction

endpackage

// File: rtl/pc_stack_if.sv
// Control/status bundle between a sequencer (master) and pc_stack (slave).
interface pc_stack_if
    import pc_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) ();

    localparam int DW = depth_w(DEPTH);

    logic [WIDTH-1:0] in;
    logic             inc;
    logic             load;
    logic             call;
    logic             ret;
    logic             stall;
    logic             err_clr;

    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output in, inc, load, call, ret, stall, err_clr,
        input  out, depth, full, empty, overflow, underflow
    );

    modport slave (
        input  in, inc, load, call, ret, stall, err_clr,
        output out, depth, full, empty, overflow, underflow
    );

endinterface

// File: rtl/ras_lifo.sv
// Return-address LIFO: storage plus registered occupancy counter. Pushes while
// full and pops while empty are ignored; the caller flags those as errors.
module ras_lifo
    import pc_stack_pkg::*;
#(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int DW    = depth_w(DEPTH),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] data,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    count;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !pop;

    assign wr_idx  = AW'(count);
    // Guarded so an empty stack never forms an out-of-range read index.
    assign top_idx = empty ? '0 : AW'(count - DW'(1));
    assign data    = mem[top_idx];
    assign depth   = count;

    // NOTE: storage is deliberately not reset; count=0 makes every entry
    // unreachable, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (do_pop) begin
            count <= count - DW'(1);
        end else if (do_push) begin
            count <= count + DW'(1);
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Program counter with return-address stack: priority op decode, registered PC
// and sticky overflow/underflow flags around a single ras_lifo instance.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    pc_stack_if.slave  bus
);

    localparam int DW = depth_w(DEPTH);

    op_e              op;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] top_data;
    logic [DW-1:0]    lifo_depth;
    logic             lifo_full;
    logic             lifo_empty;
    logic             overflow_q;
    logic             underflow_q;
    logic             overflow_set;
    logic             underflow_set;

    // NOTE: op gets a default before any branch so the decode can never
    // infer a latch.
    always_comb begin
        op = OP_HOLD;
        if (!bus.stall) begin
            if (bus.ret) begin
                op = OP_RET;
            end else if (bus.call) begin
                op = OP_CALL;
            end else if (bus.load) begin
                op = OP_LOAD;
            end else if (bus.inc) begin
                op = OP_INC;
            end
        end
    end

    // Wraps modulo 2^WIDTH; shared by inc and the call return address.
    assign pc_plus1      = pc + WIDTH'(1);
    assign overflow_set  = (op == OP_CALL) && lifo_full;
    assign underflow_set = (op == OP_RET) && lifo_empty;

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (op == OP_CALL),
        .pop       (op == OP_RET),
        .push_data (pc_plus1),
        .data      (top_data),
        .depth     (lifo_depth),
        .full      (lifo_full),
        .empty     (lifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_VECTOR;
        end else begin
            unique case (op)
                OP_INC:            pc <= pc_plus1;
                OP_LOAD, OP_CALL:  pc <= bus.in;
                OP_RET:            if (!lifo_empty) pc <= top_data;
                default:           pc <= pc;
            endcase
        end
    end

    // A new error in the same cycle as err_clr leaves the flag set; err_clr
    // still works during stall because stall forces op to HOLD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                overflow_q <= 1'b0;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end else if (bus.err_clr) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.out       = pc;
    assign bus.depth     = lifo_depth;
    assign bus.full      = lifo_full;
    assign bus.empty     = lifo_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table through a scoreboard queue,
// plus hand-written reset sequences and a RESET_VECTOR=16'h0100 instance.
module tb_pc_stack;
    import pc_stack_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = depth_w(DEPTH);

    localparam logic [5:0] B_INC   = 6'b000001;
    localparam logic [5:0] B_LOAD  = 6'b000010;
    localparam logic [5:0] B_CALL  = 6'b000100;
    localparam logic [5:0] B_RET   = 6'b001000;
    localparam logic [5:0] B_STALL = 6'b010000;
    localparam logic [5:0] B_CLR   = 6'b100000;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic [DW-1:0]    depth;
        logic             ovf;
        logic             unf;
    } exp_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] in;
        logic [5:0]       ops;
        exp_t             exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    pc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_rv ();

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VECTOR(16'h0100)) dut_rv (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_rv)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic compare_state(input string name, input exp_t e);
        check({name, ".out"},       32'(bus.out),   32'(e.out));
        check({name, ".depth"},     32'(bus.depth), 32'(e.depth));
        check({name, ".full"},      32'(bus.full),  32'(e.depth == DW'(DEPTH)));
        check({name, ".empty"},     32'(bus.empty), 32'(e.depth == '0));
        check({name, ".overflow"},  32'(bus.overflow),  32'(e.ovf));
        check({name, ".underflow"}, 32'(bus.underflow), 32'(e.unf));
    endtask

    function automatic vec_t mk(input string name, input logic [WIDTH-1:0] in,
                                input logic [5:0] ops, input logic [WIDTH-1:0] out,
                                input int d, input bit ovf, input bit unf);
        vec_t v;
        v.name      = name;
        v.in        = in;
        v.ops       = ops;
        v.exp.out   = out;
        v.exp.depth = DW'(d);
        v.exp.ovf   = ovf;
        v.exp.unf   = unf;
        return v;
    endfunction

    task automatic drive(input logic [WIDTH-1:0] in, input logic [5:0] ops);
        bus.in      = in;
        bus.inc     = ops[0];
        bus.load    = ops[1];
        bus.call    = ops[2];
        bus.ret     = ops[3];
        bus.stall   = ops[4];
        bus.err_clr = ops[5];
    endtask

    // Drive on the falling edge, expect on the next rising edge, compare 1ns later.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v.in, v.ops);
        sb_q.push_back(v.exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check({v.name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            compare_state(v.name, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        drive('0, 6'b0);
        bus_rv.in = '0; bus_rv.inc = 1'b0; bus_rv.load = 1'b0; bus_rv.call = 1'b0;
        bus_rv.ret = 1'b0; bus_rv.stall = 1'b0; bus_rv.err_clr = 1'b0;

        vecs.push_back(mk("inc1",        16'h0000, B_INC,  16'h0001, 0, 0, 0));
        vecs.push_back(mk("inc2",        16'h0000, B_INC,  16'h0002, 0, 0, 0));
        vecs.push_back(mk("inc3",        16'h0000, B_INC,  16'h0003, 0, 0, 0));
        vecs.push_back(mk("load_ffff",   16'hFFFF, B_LOAD, 16'hFFFF, 0, 0, 0));
        vecs.push_back(mk("inc_wrap",    16'h0000, B_INC,  16'h0000, 0, 0, 0));
        vecs.push_back(mk("load_0010",   16'h0010, B_LOAD, 16'h0010, 0, 0, 0));
        vecs.push_back(mk("call_0200",   16'h0200, B_CALL, 16'h0200, 1, 0, 0));
        vecs.push_back(mk("call_0300",   16'h0300, B_CALL, 16'h0300, 2, 0, 0));
        vecs.push_back(mk("ret_a",       16'h0000, B_RET,  16'h0201, 1, 0, 0));
        vecs.push_back(mk("ret_b",       16'h0000, B_RET,  16'h0011, 0, 0, 0));
        vecs.push_back(mk("load_0042",   16'h0042, B_LOAD, 16'h0042, 0, 0, 0));
        vecs.push_back(mk("ret_empty",   16'h0000, B_RET,  16'h0042, 0, 0, 1));
        vecs.push_back(mk("clr_unf",     16'h0000, B_CLR,  16'h0042, 0, 0, 0));
        vecs.push_back(mk("call_0500",   16'h0500, B_CALL, 16'h0500, 1, 0, 0));
        vecs.push_back(mk("stall_all",   16'h1234, B_STALL | B_CALL | B_LOAD | B_INC,
                          16'h0500, 1, 0, 0));
        vecs.push_back(mk("call_ret",    16'h0600, B_CALL | B_RET, 16'h0043, 0, 0, 0));
        vecs.push_back(mk("stall_ret",   16'h0000, B_STALL | B_RET, 16'h0043, 0, 0, 0));
        vecs.push_back(mk("ret_empty2",  16'h0000, B_RET,  16'h0043, 0, 0, 1));
        vecs.push_back(mk("stall_clr",   16'h0000, B_STALL | B_CLR, 16'h0043, 0, 0, 0));
        for (int k = 0; k < DEPTH; k++) begin
            vecs.push_back(mk($sformatf("fill%0d", k), 16'h1000 + 16'(k), B_CALL,
                              16'h1000 + 16'(k), k + 1, 0, 0));
        end
        vecs.push_back(mk("call_full",   16'h0ABC, B_CALL, 16'h0ABC, 8, 1, 0));
        vecs.push_back(mk("call_clr",    16'h0DEF, B_CALL | B_CLR, 16'h0DEF, 8, 1, 0));
        vecs.push_back(mk("clr_ovf",     16'h0000, B_CLR,  16'h0DEF, 8, 0, 0));
        vecs.push_back(mk("ret_top",     16'h0000, B_RET,  16'h1007, 7, 0, 0));
        vecs.push_back(mk("ret_next",    16'h0000, B_RET,  16'h1006, 6, 0, 0));

        // Reset values are checked while reset is still asserted.
        #12;
        e = '{out: 16'h0000, depth: '0, ovf: 1'b0, unf: 1'b0};
        compare_state("reset", e);
        check("reset_rv.out", 32'(bus_rv.out), 32'h0100);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Reset pulsed between edges while a call is pending.
        @(negedge clk);
        drive(16'h0777, B_CALL);
        #2;
        reset_n = 1'b0;
        #1;
        e = '{out: 16'h0000, depth: '0, ovf: 1'b0, unf: 1'b0};
        compare_state("mid_reset", e);
        check("mid_reset_rv.out", 32'(bus_rv.out), 32'h0100);
        reset_n = 1'b1;
        sb_q.push_back('{out: 16'h0777, depth: DW'(1), ovf: 1'b0, unf: 1'b0});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        compare_state("post_reset_call", e);

        apply(mk("post_reset_ret",  16'h0000, B_RET, 16'h0001, 0, 0, 0));
        apply(mk("post_reset_ret2", 16'h0000, B_RET, 16'h0001, 0, 0, 1));
        check("idle_rv.out", 32'(bus_rv.out), 32'h0100);
        check("idle_rv.empty", 32'(bus_rv.empty), 32'h1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
PC_STACK -- requirements
Module: pc_stack

Interface
REQ-001 Parameter WIDTH, default 16: program-counter and stack-entry width in bits.
REQ-002 Parameter DEPTH, default 8: return-address stack entries; legal range 2..64.
REQ-003 Parameter RESET_VECTOR, default 0: value loaded into out on reset.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port in  input  WIDTH  jump/call target address.
REQ-007 Port inc  input  1  advance out by one.
REQ-008 Port load  input  1  jump: out takes in.
REQ-009 Port call  input  1  push return address out+1, then out takes in.
REQ-010 Port ret  input  1  pop top of stack into out.
REQ-011 Port stall  input  1  freeze all state except err_clr handling.
REQ-012 Port err_clr  input  1  clear sticky error flags.
REQ-013 Port out  output  WIDTH  current program counter, registered.
REQ-014 Port depth  output  clog2(DEPTH+1)  current stack occupancy, registered.
REQ-015 Port full  output  1  high when depth == DEPTH.
REQ-016 Port empty  output  1  high when depth == 0.
REQ-017 Port overflow  output  1  sticky: a call was issued while full.
REQ-018 Port underflow  output  1  sticky: a ret was issued while empty.

Function
REQ-019 One operation per cycle, fixed priority: stall > ret > call > load > inc > hold.
REQ-020 inc: out <= out+1, modulo 2^WIDTH; all-ones wraps to 0.
REQ-021 load: out <= in; stack unchanged.
REQ-022 call, not full: stack[depth] <= out+1 (mod 2^WIDTH), depth+1, out <= in.
REQ-023 call while full: jump still taken (out <= in), push discarded, depth unchanged, overflow set.
REQ-024 ret, not empty: out <= stack[depth-1], depth-1.
REQ-025 ret while empty: out held, depth held, underflow set.
REQ-026 stall: out, depth and stack contents held regardless of other op inputs; no error flag set.
REQ-027 err_clr clears overflow and underflow next edge; a same-cycle new error wins (flag ends set).
REQ-028 full/empty are combinational decodes of registered depth; no other combinational input-to-output path.
REQ-029 Latency: every op visible on out/depth exactly one clock after the sampling edge.
REQ-030 Stack entries beyond depth are don't-care and not observable.

Reset
REQ-031 reset_n low asynchronously forces out=RESET_VECTOR, depth=0, overflow=0, underflow=0; empty=1, full=0.
REQ-032 Stack storage contents need no reset; depth=0 makes them unreachable.
REQ-033 Reset asserted mid-operation discards that operation; the first op after release is taken on the first rising edge with reset_n high.

Structure
REQ-034 Shared package pc_stack_pkg holds the op-priority enumeration (OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET) and the depth-width function.
REQ-035 Stack storage is one sub-module ras_lifo (parameters WIDTH, DEPTH; push, pop, data, depth, full, empty).
REQ-036 pc_stack holds the op decode, out register and error flags, and instantiates ras_lifo once.

Verification
REQ-037 Reset then inc x3 -> out=0,1,2,3; RESET_VECTOR=16'h0100 build -> out=16'h0100 after reset.
REQ-038 load in=16'hFFFF then inc -> out=16'hFFFF then 16'h0000.
REQ-039 out=16'h0010, call in=16'h0200; call in=16'h0300; ret; ret -> out=0200, 0300, 0201, 0011; depth=1, 2, 1, 0; empty after last.
REQ-040 8 calls fill stack (full=1); 9th call in=16'h0ABC -> out=0ABC, depth=8, overflow=1; err_clr -> overflow=0.
REQ-041 ret while empty at out=16'h0042 -> out stays 0042, underflow=1; stall with call+load+inc all high -> out, depth unchanged.
REQ-042 call+ret same cycle with depth=1 -> ret wins; reset_n pulsed low mid-call between edges -> out=RESET_VECTOR, depth=0 immediately, no push recorded.
